// File: rtl/reservation_station_param.sv
// Parametrised age-ordered (collapsing) reservation station.
// Oldest ready entry issues over valid/ready. Result buses are snooped for
// operand wakeup, with a same-cycle bypass for operands being allocated.
module reservation_station_param #(
   parameter int DEPTH   = 8,
   parameter int NUM_FWD = 4,
   parameter int TAG_W   = 6,
   parameter int DATA_W  = 16,
   parameter int OP_W    = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          flush,
   input  logic                          inValid,
   output logic                          inReady,
   input  logic [OP_W-1:0]               inOp,
   input  logic [TAG_W-1:0]              inRob,
   input  logic [TAG_W-1:0]              inTagA,
   input  logic [TAG_W-1:0]              inTagB,
   input  logic [DATA_W-1:0]             inValA,
   input  logic [DATA_W-1:0]             inValB,
   input  logic                          inPendA,
   input  logic                          inPendB,
   input  logic [NUM_FWD-1:0]            fwdValid,
   input  logic [NUM_FWD*TAG_W-1:0]      fwdTag,
   input  logic [NUM_FWD*DATA_W-1:0]     fwdData,
   output logic                          outValid,
   input  logic                          outReady,
   output logic [OP_W-1:0]               outOp,
   output logic [TAG_W-1:0]              outRob,
   output logic [DATA_W-1:0]             outA,
   output logic [DATA_W-1:0]             outB,
   output logic [$clog2(DEPTH+1)-1:0]    count
);
   localparam int CW = $clog2(DEPTH+1);
   localparam int IW = $clog2(DEPTH);

   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [TAG_W-1:0]  rob;
      logic [TAG_W-1:0]  tag_a;
      logic [TAG_W-1:0]  tag_b;
      logic [DATA_W-1:0] val_a;
      logic [DATA_W-1:0] val_b;
      logic              pend_a;
      logic              pend_b;
   } entry_t;

   entry_t          ent     [DEPTH];
   entry_t          ent_nxt [DEPTH];
   entry_t          new_ent;
   logic [IW-1:0]   sel;
   logic            issue;
   logic            alloc;
   logic [CW-1:0]   cnt_nxt;
   logic [CW-1:0]   wr_idx;

   // {hit, data} of the lowest-numbered valid bus carrying this tag
   function automatic logic [DATA_W:0] snoop(
      input logic [TAG_W-1:0]          tag,
      input logic [NUM_FWD-1:0]        v,
      input logic [NUM_FWD*TAG_W-1:0]  t,
      input logic [NUM_FWD*DATA_W-1:0] d);
      snoop = '0;
      for (int k = NUM_FWD-1; k >= 0; k--)
         if (v[k] && t[k*TAG_W +: TAG_W] == tag) snoop = {1'b1, d[k*DATA_W +: DATA_W]};
   endfunction

   // Oldest-first select; falls back to entry 0 when nothing is ready
   always_comb begin
      sel      = '0;
      outValid = 1'b0;
      for (int i = DEPTH-1; i >= 0; i--)
         if (CW'(i) < count && !ent[i].pend_a && !ent[i].pend_b) begin
            sel      = IW'(i);
            outValid = 1'b1;
         end
      outOp  = ent[sel].op;
      outRob = ent[sel].rob;
      outA   = ent[sel].val_a;
      outB   = ent[sel].val_b;
   end

   assign inReady = (count < CW'(DEPTH));
   assign issue   = outValid && outReady;
   assign alloc   = inValid && inReady;
   assign cnt_nxt = count + CW'(alloc) - CW'(issue);
   assign wr_idx  = count - CW'(issue);

   // Incoming entry, with operands bypassed from this cycle's result buses
   always_comb begin
      logic [DATA_W:0] hit;
      new_ent = '{op: inOp, rob: inRob, tag_a: inTagA, tag_b: inTagB,
                  val_a: inValA, val_b: inValB, pend_a: inPendA, pend_b: inPendB};
      hit = snoop(inTagA, fwdValid, fwdTag, fwdData);
      if (inPendA && hit[DATA_W]) begin
         new_ent.val_a  = hit[DATA_W-1:0];
         new_ent.pend_a = 1'b0;
      end
      hit = snoop(inTagB, fwdValid, fwdTag, fwdData);
      if (inPendB && hit[DATA_W]) begin
         new_ent.val_b  = hit[DATA_W-1:0];
         new_ent.pend_b = 1'b0;
      end
   end

   // Collapse above the issued slot, wake operands in their new position,
   // then drop the new entry into the first free slot
   always_comb begin
      entry_t          src;
      logic [DATA_W:0] hit;
      for (int j = 0; j < DEPTH; j++) begin
         src = ent[j];
         if (issue && j >= int'(sel)) src = ent[(j == DEPTH-1) ? j : j+1];
         hit = snoop(src.tag_a, fwdValid, fwdTag, fwdData);
         if (src.pend_a && hit[DATA_W]) begin
            src.val_a  = hit[DATA_W-1:0];
            src.pend_a = 1'b0;
         end
         hit = snoop(src.tag_b, fwdValid, fwdTag, fwdData);
         if (src.pend_b && hit[DATA_W]) begin
            src.val_b  = hit[DATA_W-1:0];
            src.pend_b = 1'b0;
         end
         if (CW'(j) >= cnt_nxt) begin
            src.pend_a = 1'b0;
            src.pend_b = 1'b0;
         end
         if (alloc && CW'(j) == wr_idx) src = new_ent;
         ent_nxt[j] = src;
      end
   end

   // State update; flush beats any same-cycle allocation or issue
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
         for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      end else if (flush) begin
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent[i].pend_a <= 1'b0;
            ent[i].pend_b <= 1'b0;
         end
      end else begin
         count <= cnt_nxt;
         for (int i = 0; i < DEPTH; i++) ent[i] <= ent_nxt[i];
      end
   end
endmodule

// File: tb/tb_reservation_station_param.sv
// Directed bench: queue-based model checked every cycle plus literal pins.
module tb_reservation_station_param;
   localparam int DEPTH = 8, NUM_FWD = 4, TAG_W = 6, DATA_W = 16, OP_W = 4;
   localparam int CW = $clog2(DEPTH+1);

   logic clk = 0, reset = 1, flush = 0;
   logic inValid = 0, inReady, inPendA = 0, inPendB = 0, outValid, outReady = 0;
   logic [OP_W-1:0] inOp = 0, outOp;
   logic [TAG_W-1:0] inRob = 0, inTagA = 0, inTagB = 0, outRob;
   logic [DATA_W-1:0] inValA = 0, inValB = 0, outA, outB;
   logic [NUM_FWD-1:0] fv = 0;
   logic [TAG_W-1:0] ft [NUM_FWD];
   logic [DATA_W-1:0] fd [NUM_FWD];
   logic [NUM_FWD*TAG_W-1:0] fwdTag;
   logic [NUM_FWD*DATA_W-1:0] fwdData;
   logic [CW-1:0] count;

   int checks = 0, failures = 0;
   bit chk_en = 0;

   always #5 clk = ~clk;

   always_comb begin
      fwdTag = '0; fwdData = '0;
      for (int k = 0; k < NUM_FWD; k++) begin
         fwdTag[k*TAG_W +: TAG_W]   = ft[k];
         fwdData[k*DATA_W +: DATA_W] = fd[k];
      end
   end

   reservation_station_param #(.DEPTH(DEPTH), .NUM_FWD(NUM_FWD), .TAG_W(TAG_W),
      .DATA_W(DATA_W), .OP_W(OP_W)) dut (
      .clk(clk), .reset(reset), .flush(flush), .inValid(inValid), .inReady(inReady),
      .inOp(inOp), .inRob(inRob), .inTagA(inTagA), .inTagB(inTagB),
      .inValA(inValA), .inValB(inValB), .inPendA(inPendA), .inPendB(inPendB),
      .fwdValid(fv), .fwdTag(fwdTag), .fwdData(fwdData),
      .outValid(outValid), .outReady(outReady), .outOp(outOp), .outRob(outRob),
      .outA(outA), .outB(outB), .count(count));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- model: age-ordered list of entries ----------------
   typedef struct {
      int op, rob, ta, tb, a, b;
      bit pa, pb;
   } m_e;
   m_e q[$];

   function automatic int first_ready();
      for (int i = 0; i < q.size(); i++) if (!q[i].pa && !q[i].pb) return i;
      return -1;
   endfunction

   // lowest bus carrying tag, or -1
   function automatic int bus_for(int tag);
      for (int k = 0; k < NUM_FWD; k++) if (fv[k] && int'(ft[k]) == tag) return k;
      return -1;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset || flush) q.delete();
      else begin
         int r, k;
         bit alc;
         m_e n;
         r = first_ready();
         alc = inValid && q.size() < DEPTH;
         if (r >= 0 && outReady) q.delete(r);
         foreach (q[i]) begin
            k = bus_for(q[i].ta);
            if (q[i].pa && k >= 0) begin q[i].a = int'(fd[k]); q[i].pa = 0; end
            k = bus_for(q[i].tb);
            if (q[i].pb && k >= 0) begin q[i].b = int'(fd[k]); q[i].pb = 0; end
         end
         if (alc) begin
            n = '{op: int'(inOp), rob: int'(inRob), ta: int'(inTagA), tb: int'(inTagB),
                  a: int'(inValA), b: int'(inValB), pa: inPendA, pb: inPendB};
            k = bus_for(n.ta);
            if (n.pa && k >= 0) begin n.a = int'(fd[k]); n.pa = 0; end
            k = bus_for(n.tb);
            if (n.pb && k >= 0) begin n.b = int'(fd[k]); n.pb = 0; end
            q.push_back(n);
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (chk_en && !reset) begin
         int r;
         r = first_ready();
         chk("count", 32'(count), 32'(q.size()));
         chk("inReady", 32'(inReady), 32'(q.size() < DEPTH));
         chk("outValid", 32'(outValid), 32'(r >= 0));
         if (r >= 0 && outValid) begin
            chk("outOp", 32'(outOp), 32'(q[r].op));
            chk("outRob", 32'(outRob), 32'(q[r].rob));
            chk("outA", 32'(outA), 32'(q[r].a));
            chk("outB", 32'(outB), 32'(q[r].b));
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic drive(input int op, rob, ta, tb, va, vb, input bit pa, pb);
      inValid = 1; inOp = OP_W'(op); inRob = TAG_W'(rob);
      inTagA = TAG_W'(ta); inTagB = TAG_W'(tb);
      inValA = DATA_W'(va); inValB = DATA_W'(vb); inPendA = pa; inPendB = pb;
   endtask

   task automatic clear_fwd();
      fv = '0;
      for (int k = 0; k < NUM_FWD; k++) begin ft[k] = '0; fd[k] = '0; end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      clear_fwd();
      #12 reset = 0; #1;
      chk("rst_count", 32'(count), 0);
      chk("rst_inReady", 32'(inReady), 1);
      chk("rst_outValid", 32'(outValid), 0);
      chk_en = 1;
      tick();

      // reset mid-fill
      for (int i = 1; i <= 3; i++) begin drive(1, i, 0, 0, i, i, 0, 0); tick(); end
      inValid = 0;
      chk("fill3_count", 32'(count), 3);
      #2 reset = 1; #1;
      chk("midrst_count", 32'(count), 0);
      chk("midrst_outValid", 32'(outValid), 0);
      chk("midrst_inReady", 32'(inReady), 1);
      #1 reset = 0;
      tick();

      // ordering, full behaviour
      for (int i = 1; i <= 8; i++) begin drive(i, i, 0, 0, 16*i, i, 0, 0); tick(); end
      chk("full_count", 32'(count), 8);
      chk("full_inReady", 32'(inReady), 0);
      drive(2, 99, 0, 0, 0, 0, 0, 0); outReady = 1;
      chk("order_rob1", 32'(outRob), 1);
      tick();
      chk("full_noreuse_count", 32'(count), 7);
      inValid = 0;
      for (int i = 2; i <= 8; i++) begin chk("order_rob", 32'(outRob), 32'(i)); tick(); end
      chk("drain_count", 32'(count), 0);

      // forward wakeup
      drive(3, 5, 6'h12, 0, 0, 16'h0042, 1, 0); tick(); inValid = 0;
      chk("fwd_pending", 32'(outValid), 0);
      fv = 4'b0100; ft[2] = 6'h13; fd[2] = 16'hBEEF; tick();
      chk("fwd_nomatch", 32'(outValid), 0);
      ft[2] = 6'h12;
      chk("fwd_cycleN", 32'(outValid), 0);
      tick(); clear_fwd();
      chk("fwd_valid", 32'(outValid), 1);
      chk("fwd_outA", 32'(outA), 32'hBEEF);
      chk("fwd_rob", 32'(outRob), 5);
      tick();

      // bypass with multi-match; non-pending operand ignores the bus
      outReady = 0;
      fv = 4'b1001; ft[0] = 6'h07; fd[0] = 16'h1111; ft[3] = 6'h07; fd[3] = 16'h3333;
      drive(4, 9, 6'h07, 6'h07, 16'h5555, 0, 0, 1); tick(); inValid = 0; clear_fwd();
      chk("byp_valid", 32'(outValid), 1);
      chk("byp_outB", 32'(outB), 32'h1111);
      chk("byp_outA", 32'(outA), 32'h5555);
      outReady = 1; tick();

      // out-of-order readiness
      outReady = 0;
      drive(5, 10, 6'h20, 0, 0, 7, 1, 0); tick();
      drive(6, 11, 0, 0, 1, 2, 0, 0); tick(); inValid = 0;
      chk("ooo_rob11", 32'(outRob), 11);
      outReady = 1; tick();
      chk("ooo_count", 32'(count), 1);
      chk("ooo_still_pend", 32'(outValid), 0);
      fv = 4'b0010; ft[1] = 6'h20; fd[1] = 16'hAAAA; tick(); clear_fwd();
      chk("ooo_wake", 32'(outRob), 10);
      chk("ooo_wakeA", 32'(outA), 32'hAAAA);
      tick();

      // simultaneous alloc/issue, then flush
      outReady = 0;
      for (int i = 20; i <= 22; i++) begin drive(7, i, 0, 0, i, i, 0, 0); tick(); end
      drive(7, 23, 0, 0, 23, 23, 0, 0); outReady = 1; tick();
      chk("simul_count", 32'(count), 3);
      chk("simul_rob", 32'(outRob), 21);
      drive(8, 30, 0, 0, 1, 1, 0, 0); flush = 1; tick();
      flush = 0; inValid = 0;
      chk("flush_count", 32'(count), 0);
      chk("flush_outValid", 32'(outValid), 0);
      tick();

      chk_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/reservation_station_param.md
Name: reservation_station_param

Overview:
- Parametrised successor to the 5-entry reservation station: DEPTH entries, NUM_FWD forward buses, configurable tag and data widths.
- Entries are kept in age order (collapsing queue). The oldest ready entry issues over a valid/ready handshake and its slot is freed on issue.
- Adds same-cycle forward bypass on allocation, a synchronous flush, and an occupancy output.
- Sits between decode/rename (allocation side) and one functional unit (issue side), snooping all result buses.

Parameters:
DEPTH, 8, number of entries (2..16)
NUM_FWD, 4, number of forwarding/result buses
TAG_W, 6, ROB tag width
DATA_W, 16, operand width
OP_W, 4, opcode width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous clear of all entries (mispredict)
inValid  in  1  allocation request
inReady  out  1  space available; allocation accepted when inValid && inReady
inOp  in  OP_W  opcode
inRob  in  TAG_W  destination ROB tag
inTagA / inTagB  in  TAG_W  producer tags for operands A/B
inValA / inValB  in  DATA_W  operand values (meaningful when not pending)
inPendA / inPendB  in  1  operand awaiting forward
fwdValid  in  NUM_FWD  per-bus valid
fwdTag  in  NUM_FWD*TAG_W  bus k occupies bits [k*TAG_W +: TAG_W]
fwdData  in  NUM_FWD*DATA_W  bus k occupies bits [k*DATA_W +: DATA_W]
outValid  out  1  a ready entry is presented
outReady  in  1  functional unit accepts
outOp  out  OP_W  issued opcode
outRob  out  TAG_W  issued ROB tag
outA / outB  out  DATA_W  issued operand values
count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (async, any time, including mid-operation): count=0 and all entry valid/pending bits cleared; outValid=0, inReady=1. Outputs outOp/outRob/outA/outB are don't-care while outValid=0.
- Storage: entries 0..count-1 are valid. Entry 0 is the oldest. Each entry holds op, rob, tagA, tagB, valA, valB, pendA, pendB.
- Entry ready = valid && !pendA && !pendB.
- Issue is combinational from registered state. outValid = any ready entry. Outputs come from the lowest-index ready entry (oldest-first). No 3'b111 fallback: when outValid=0, outputs are held at the entry-0 fields.
- Issue fires when outValid && outReady. At the clock edge the issued entry is removed, entries above it shift down one index (order preserved), and count decrements.
- inReady = (count < DEPTH), from registered count only. When full, inReady=0 even if an issue fires that cycle. No same-cycle slot reuse when full.
- Allocation fires when inValid && inReady. The new entry is written at index count, or count-1 if an issue also fires. count is net unchanged on simultaneous alloc and issue.
- Forwarding on stored entries:
  - Every valid entry with pendX=1 compares tagX against each fwdTag[k] with fwdValid[k]=1.
  - On a match: valX <= fwdData[k], pendX <= 0.
  - Applies to the post-shift position, so shifted entries still capture forwards.
  - If multiple buses match the same tag, the lowest k wins.
- Allocation bypass: an incoming operand with inPend=1 whose tag matches a valid forward bus in the allocation cycle is stored with pend=0 and the bus data. An operand with inPend=0 ignores forwards.
- Latency:
  - An allocated entry with both operands non-pending (or bypassed) can issue the next cycle.
  - A forward arriving in cycle N makes the entry issuable in cycle N+1.
- An entry issued this cycle ignores forwards (it is removed).
- flush: at the edge, count<=0 and all entries are invalidated. flush overrides any same-cycle allocation and issue; the FU must ignore an issue accepted in the flush cycle.
- count never exceeds DEPTH and never underflows.

Test Plan:
- Reset mid-fill: allocate 3 ready entries, assert reset between edges -> count=0, outValid=0, inReady=1 immediately (no clock edge needed).
- Ordering: DEPTH=8, fill 8 entries rob 1..8, all ready, outReady=1 -> inReady=0 at count=8; issue order rob 1,2,...,8 on consecutive cycles; count reaches 0.
- Forward wakeup:
  - Entry rob=5 pendA tagA=0x12. Drive fwdValid[2]=1, fwdTag bus2=0x12, fwdData=0xBEEF in cycle N.
  - Required: outValid=1 in cycle N+1 with outA=0xBEEF.
  - Non-matching tag 0x13 leaves the entry pending.
- Bypass and multi-match:
  - Allocate pendB tagB=0x07 while bus0 and bus3 both carry tag 0x07 with data 0x1111 and 0x3333.
  - Required: entry stored with B=0x1111 and issues the next cycle.
- Out-of-order readiness: entry0 pending, entry1 ready -> entry1 issues; entry0 shifts to index 0 and keeps its pending state; it later wakes via a forward and issues.
- Simultaneous alloc/issue at count=3 -> count stays 3; new entry is youngest. Assert flush together with inValid and outReady -> count=0 next cycle, new entry discarded.
